hs32_mem_arb: RTL and testbench
===============================

HS32_MEM_ARB -- requirements
Module: hs32_mem_arb

Interface
REQ-001 Parameter: ADDR_WIDTH, default 8, byte-address width shared by all ports; matches the downstream storage block.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 i_addr  input  ADDR_WIDTH  instruction-fetch byte address.
REQ-005 i_valid  input  1  instruction read request.
REQ-006 i_ready  output  1  one-cycle completion pulse to instruction port.
REQ-007 i_dread  output  32  instruction read data.
REQ-008 d_addr  input  ADDR_WIDTH  data-port byte address.
REQ-009 d_dwrite  input  32  data-port write data.
REQ-010 d_rw  input  1  data-port direction, 1 = write, 0 = read.
REQ-011 d_valid  input  1  data-port request.
REQ-012 d_ready  output  1  one-cycle completion pulse to data port.
REQ-013 d_dread  output  32  data-port read data.
REQ-014 m_addr  output  ADDR_WIDTH  address to storage.
REQ-015 m_dwrite  output  32  write data to storage.
REQ-016 m_rw  output  1  direction to storage.
REQ-017 m_valid  output  1  request to storage.
REQ-018 m_ready  input  1  storage completion.
REQ-019 m_dread  input  32  storage read data, valid when m_ready is high.
REQ-020 grant  output  1  owner of the current or last transaction, 0 = instruction, 1 = data.

Function
REQ-021 FSM states: IDLE, REQ, RESP; only these three.
REQ-022 IDLE, neither valid: stay in IDLE; m_valid=0.
REQ-023 IDLE, exactly one valid: grant that port.
REQ-024 IDLE, both valid: round-robin; grant = !last_grant; last_grant <= grant.
REQ-025 IDLE, on grant: register addr, dwrite and rw into the m_* outputs; set m_valid=1; go to REQ.
REQ-026 Instruction grants: m_rw=0 and m_dwrite=0.
REQ-027 REQ: m_valid, m_addr, m_dwrite and m_rw are held stable until m_ready is sampled high.
REQ-028 REQ with m_ready=1:
- m_valid <= 0
- granted port's dread <= m_dread
- granted port's ready <= 1
- go to RESP
REQ-029 m_dread is captured into the granted port's dread on writes too.
REQ-030 RESP: granted port's ready is high for exactly this cycle; next state IDLE.
REQ-031 RESP: all valid inputs are ignored, so a requester's stale valid is never re-accepted.
REQ-032 Latency:
- accept at edge t; m_valid high from t.
- m_ready sampled at edge t+k, k>=1.
- port ready high in the cycle after edge t+k.
- minimum 3 cycles IDLE-to-IDLE.
REQ-033 The ungranted port's ready stays 0 and its dread holds its last value.
REQ-034 Requesters SHALL hold valid and payload until their ready pulse; valid is sampled only in IDLE.
REQ-035 m_ready is ignored in IDLE and RESP.
REQ-036 i_ready and d_ready are never high in the same cycle.
REQ-037 At most one transaction is outstanding.

Reset
REQ-038 On reset, asynchronously:
- state=IDLE, last_grant=0, grant=0
- m_valid=0, m_rw=0, m_addr=0, m_dwrite=0
- i_ready=0, d_ready=0, i_dread=0, d_dread=0
REQ-039 Reset during REQ or RESP abandons the transaction.
REQ-040 After reset, no ready pulse is produced for an abandoned transaction, including when a late m_ready arrives in IDLE.

Verification
REQ-041 i_valid, i_addr=0x10; storage returns m_dread=0xDEADBEEF after 1 cycle:
- m_rw=0
- i_ready pulses once with i_dread=0xDEADBEEF
- d_ready stays 0
REQ-042 d_valid, d_rw=1, d_addr=0x23, d_dwrite=0x11223344:
- m_addr=0x23, m_rw=1, m_dwrite=0x11223344, stable until m_ready
- single d_ready pulse
REQ-043 i_valid and d_valid asserted together from reset, each re-requesting after its ready:
- grant order D, I, D, I
- no two ready pulses in the same cycle
REQ-044 m_ready delayed 5 cycles: m_valid and payload held constant for all 5 cycles; response arrives 1 cycle after m_ready.
REQ-045 Reset asserted in REQ, then m_ready pulsed after release:
- m_valid=0 immediately
- no i_ready or d_ready pulse
- next request served normally

Source files
------------

// File: rtl/hs32_mem_arb_if.sv
// +----------------------------------------------------------------------------+
// | hs32_mem_arb_if                                                            |
// | Instruction, data and storage-side signals of the two-port memory arbiter. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface hs32_mem_arb_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_valid;
  logic                  i_ready;
  logic [31:0]           i_dread;

  logic [ADDR_WIDTH-1:0] d_addr;
  logic [31:0]           d_dwrite;
  logic                  d_rw;
  logic                  d_valid;
  logic                  d_ready;
  logic [31:0]           d_dread;

  logic [ADDR_WIDTH-1:0] m_addr;
  logic [31:0]           m_dwrite;
  logic                  m_rw;
  logic                  m_valid;
  logic                  m_ready;
  logic [31:0]           m_dread;

  logic                  grant;

  // master: the arbiter itself, which masters the storage side
  modport master (
    input  i_addr, i_valid, d_addr, d_dwrite, d_rw, d_valid, m_ready, m_dread,
    output i_ready, i_dread, d_ready, d_dread, m_addr, m_dwrite, m_rw, m_valid, grant
  );

  modport slave (
    output i_addr, i_valid, d_addr, d_dwrite, d_rw, d_valid, m_ready, m_dread,
    input  i_ready, i_dread, d_ready, d_dread, m_addr, m_dwrite, m_rw, m_valid, grant
  );
endinterface

`default_nettype wire

// File: rtl/hs32_mem_arb.sv
// +----------------------------------------------------------------------------+
// | hs32_mem_arb                                                               |
// | Round-robin arbiter sharing one storage port between I-fetch and data.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module hs32_mem_arb #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  hs32_mem_arb_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  // r_grant doubles as the round-robin history: it always names the last owner
  logic                  r_grant,    w_grant_next;
  logic [ADDR_WIDTH-1:0] r_m_addr,   w_m_addr_next;
  logic [31:0]           r_m_dwrite, w_m_dwrite_next;
  logic                  r_m_rw,     w_m_rw_next;
  logic                  r_m_valid,  w_m_valid_next;
  logic                  r_i_ready,  w_i_ready_next;
  logic                  r_d_ready,  w_d_ready_next;
  logic [31:0]           r_i_dread,  w_i_dread_next;
  logic [31:0]           r_d_dread,  w_d_dread_next;
  logic                  w_owner;

  always_comb begin
    w_state_next    = r_state;
    w_grant_next    = r_grant;
    w_m_addr_next   = r_m_addr;
    w_m_dwrite_next = r_m_dwrite;
    w_m_rw_next     = r_m_rw;
    w_m_valid_next  = r_m_valid;
    w_i_ready_next  = 1'b0;
    w_d_ready_next  = 1'b0;
    w_i_dread_next  = r_i_dread;
    w_d_dread_next  = r_d_dread;
    w_owner         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.i_valid || bus.d_valid) begin
          w_owner         = (bus.i_valid && bus.d_valid) ? ~r_grant : bus.d_valid;
          w_grant_next    = w_owner;
          w_m_addr_next   = w_owner ? bus.d_addr   : bus.i_addr;
          w_m_dwrite_next = w_owner ? bus.d_dwrite : 32'd0;
          w_m_rw_next     = w_owner ? bus.d_rw     : 1'b0;
          w_m_valid_next  = 1'b1;
          w_state_next    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.m_ready) begin
          w_m_valid_next = 1'b0;
          if (r_grant) begin
            w_d_dread_next = bus.m_dread;
            w_d_ready_next = 1'b1;
          end else begin
            w_i_dread_next = bus.m_dread;
            w_i_ready_next = 1'b1;
          end
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= 1'b0;
      r_m_addr   <= '0;
      r_m_dwrite <= 32'd0;
      r_m_rw     <= 1'b0;
      r_m_valid  <= 1'b0;
      r_i_ready  <= 1'b0;
      r_d_ready  <= 1'b0;
      r_i_dread  <= 32'd0;
      r_d_dread  <= 32'd0;
    end else begin
      r_state    <= w_state_next;
      r_grant    <= w_grant_next;
      r_m_addr   <= w_m_addr_next;
      r_m_dwrite <= w_m_dwrite_next;
      r_m_rw     <= w_m_rw_next;
      r_m_valid  <= w_m_valid_next;
      r_i_ready  <= w_i_ready_next;
      r_d_ready  <= w_d_ready_next;
      r_i_dread  <= w_i_dread_next;
      r_d_dread  <= w_d_dread_next;
    end
  end

  assign bus.grant    = r_grant;
  assign bus.m_addr   = r_m_addr;
  assign bus.m_dwrite = r_m_dwrite;
  assign bus.m_rw     = r_m_rw;
  assign bus.m_valid  = r_m_valid;
  assign bus.i_ready  = r_i_ready;
  assign bus.d_ready  = r_d_ready;
  assign bus.i_dread  = r_i_dread;
  assign bus.d_dread  = r_d_dread;

endmodule

`default_nettype wire

// File: tb/tb_hs32_mem_arb.sv
// +----------------------------------------------------------------------------+
// | tb_hs32_mem_arb                                                            |
// | Directed plus randomized bench against a transaction-level arbiter model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hs32_mem_arb;

  logic clk;
  logic reset;

  hs32_mem_arb_if #(.ADDR_WIDTH(8)) bus ();

  hs32_mem_arb #(.ADDR_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Transaction-level model: pending requests, payloads, last owner, held read data
  bit          pi, pd;
  logic [7:0]  ai, ad;
  logic [31:0] wd;
  logic        rwd;
  bit          last;
  logic [31:0] hi, hd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    bus.i_valid  = pi;
    bus.i_addr   = ai;
    bus.d_valid  = pd;
    bus.d_addr   = ad;
    bus.d_dwrite = wd;
    bus.d_rw     = rwd;
  endtask

  task automatic model_reset();
    last = 1'b0;
    hi   = 32'd0;
    hd   = 32'd0;
  endtask

  // Starts in IDLE with the model's requests pending; storage answers after dly cycles.
  task automatic transact(input int dly, input logic [31:0] rdata);
    bit          owner;
    logic [7:0]  e_addr;
    logic [31:0] e_wd;
    logic        e_rw;
    owner  = (pi && pd) ? !last : pd;
    last   = owner;
    e_addr = owner ? ad : ai;
    e_wd   = owner ? wd : 32'd0;
    e_rw   = owner ? rwd : 1'b0;
    drive();
    bus.m_ready = 1'b0;
    step();
    chk("accept_m_valid", bus.m_valid, 1);
    chk("accept_grant", bus.grant, owner);
    chk("accept_m_addr", bus.m_addr, e_addr);
    chk("accept_m_dwrite", bus.m_dwrite, e_wd);
    chk("accept_m_rw", bus.m_rw, e_rw);
    chk("accept_no_ready", {bus.i_ready, bus.d_ready}, 0);
    for (int c = 1; c < dly; c++) begin
      step();
      chk("hold_m_valid", bus.m_valid, 1);
      chk("hold_m_addr", bus.m_addr, e_addr);
      chk("hold_m_dwrite", bus.m_dwrite, e_wd);
      chk("hold_m_rw", bus.m_rw, e_rw);
      chk("hold_no_ready", {bus.i_ready, bus.d_ready}, 0);
    end
    bus.m_ready = 1'b1;
    bus.m_dread = rdata;
    step();
    bus.m_ready = 1'b0;
    bus.m_dread = $urandom;
    if (owner) hd = rdata;
    else       hi = rdata;
    chk("resp_i_ready", bus.i_ready, !owner);
    chk("resp_d_ready", bus.d_ready, owner);
    chk("resp_i_dread", bus.i_dread, hi);
    chk("resp_d_dread", bus.d_dread, hd);
    chk("resp_m_valid", bus.m_valid, 0);
    // owner's valid stays stale through the response cycle and must not be re-accepted
    step();
    chk("post_no_ready", {bus.i_ready, bus.d_ready}, 0);
    chk("post_m_valid", bus.m_valid, 0);
    if (owner) pd = 1'b0;
    else       pi = 1'b0;
  endtask

  logic [0:3] rr_exp;

  initial begin
    reset        = 1'b1;
    bus.i_valid  = 1'b0;
    bus.i_addr   = '0;
    bus.d_valid  = 1'b0;
    bus.d_addr   = '0;
    bus.d_dwrite = 32'd0;
    bus.d_rw     = 1'b0;
    bus.m_ready  = 1'b0;
    bus.m_dread  = 32'd0;
    pi = 0; pd = 0; ai = 0; ad = 0; wd = 0; rwd = 0;
    model_reset();
    step();
    step();
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_dwrite", bus.m_dwrite, 0);
    chk("rst_m_rw", bus.m_rw, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_ready", {bus.i_ready, bus.d_ready}, 0);
    chk("rst_i_dread", bus.i_dread, 0);
    chk("rst_d_dread", bus.d_dread, 0);
    reset = 1'b0;
    step();

    // Instruction read of 0x10, one-cycle storage latency
    pi = 1; ai = 8'h10;
    transact(1, 32'hDEADBEEF);
    chk("ifetch_dread", bus.i_dread, 32'hDEADBEEF);

    // Data write
    pd = 1; ad = 8'h23; wd = 32'h11223344; rwd = 1;
    transact(2, 32'hCAFE0001);

    // Slow storage: five-cycle response
    pi = 1; ai = 8'h44;
    transact(5, 32'h0BADF00D);

    // Idle with a spurious m_ready
    drive();
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
    chk("idle_m_valid", bus.m_valid, 0);
    chk("idle_no_ready", {bus.i_ready, bus.d_ready}, 0);
    step();
    chk("idle_no_ready2", {bus.i_ready, bus.d_ready}, 0);

    // Reset in the middle of a transaction, then a late m_ready
    pd = 1; ad = 8'h55; wd = 32'h5555AAAA; rwd = 0;
    drive();
    step();
    chk("abort_m_valid_pre", bus.m_valid, 1);
    reset = 1'b1;
    #1;
    chk("abort_m_valid_async", bus.m_valid, 0);
    chk("abort_grant", bus.grant, 0);
    chk("abort_d_dread", bus.d_dread, 0);
    model_reset();
    pd = 0;
    drive();
    step();
    reset = 1'b0;
    step();
    bus.m_ready = 1'b1;
    bus.m_dread = 32'h12345678;
    step();
    bus.m_ready = 1'b0;
    chk("abort_no_ready", {bus.i_ready, bus.d_ready}, 0);
    step();
    chk("abort_no_ready2", {bus.i_ready, bus.d_ready}, 0);
    pi = 1; ai = 8'h66;
    transact(1, 32'hA5A5A5A5);

    // Both ports competing from reset: D, I, D, I
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    rr_exp = 4'b1010;
    pi = 1; ai = 8'h70; pd = 1; ad = 8'h80; wd = 32'h0; rwd = 0;
    for (int n = 0; n < 4; n++) begin
      transact(1 + n, $urandom);
      chk("rr_order", bus.grant, rr_exp[n]);
      if (!pi) begin pi = 1; ai = ai + 8'd1; end
      if (!pd) begin pd = 1; ad = ad + 8'd1; end
    end

    // Randomized traffic; unserved requests keep their payload pending
    for (int n = 0; n < 40; n++) begin
      if (!pi && ($urandom_range(0, 1) == 1)) begin
        pi = 1; ai = 8'($urandom);
      end
      if (!pd && ($urandom_range(0, 1) == 1)) begin
        pd = 1; ad = 8'($urandom); wd = $urandom; rwd = 1'($urandom);
      end
      if (!pi && !pd) begin
        pi = 1; ai = 8'($urandom);
      end
      transact(int'($urandom_range(1, 6)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
